// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: keeps one fetch in flight to
// instruction memory, hands each returned word to decode, and follows trap/redirect targets.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc, pc_nx;
  logic              kill, kill_nx;
  logic [XLEN-1:0]   inst_nx, inst_pc_nx;
  logic              valid_nx, fault_nx;

  // Control-flow event: trap outranks redirect; a redirect coincident with a trap is lost.
  logic              evt;
  logic [XLEN-1:0]   tgt;
  logic              tgt_mis;

  always_comb begin
    evt     = trap_valid | redirect_valid;
    tgt     = trap_valid ? trap_vector : redirect_target;
    tgt_mis = evt && (tgt[1:0] != 2'b00);
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    kill_nx    = kill;
    inst_nx    = inst;
    inst_pc_nx = inst_pc;
    valid_nx   = inst_valid;
    fault_nx   = misalign_fault;

    case (state)
      IDLE: begin
        if (tgt_mis) begin
          fault_nx = 1'b1;
          state_nx = FAULT;
        end else begin
          if (evt) pc_nx = tgt;
          state_nx = REQ;
        end
      end

      REQ: begin
        if (evt) begin
          // A grant in the same cycle belongs to the old address; its response is stale.
          if (imem_gnt) kill_nx = 1'b1;
          if (tgt_mis) begin
            fault_nx = 1'b1;
            state_nx = FAULT;
          end else begin
            pc_nx = tgt;
            if (imem_gnt) state_nx = WAIT;
          end
        end else if (imem_gnt) begin
          state_nx = WAIT;
        end
      end

      WAIT: begin
        if (evt) begin
          kill_nx = !imem_rvalid;
          if (tgt_mis) begin
            fault_nx = 1'b1;
            state_nx = FAULT;
          end else begin
            pc_nx = tgt;
            if (imem_rvalid) state_nx = REQ;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_nx  = 1'b0;
            state_nx = REQ;
          end else begin
            inst_nx    = imem_rdata;
            inst_pc_nx = pc;
            valid_nx   = 1'b1;
            pc_nx      = pc + XLEN'(4);
            state_nx   = HOLD;
          end
        end
      end

      HOLD: begin
        if (evt) begin
          valid_nx = 1'b0;
          if (tgt_mis) begin
            fault_nx = 1'b1;
            state_nx = FAULT;
          end else begin
            pc_nx    = tgt;
            state_nx = REQ;
          end
        end else if (!stall) begin
          valid_nx = 1'b0;
          state_nx = REQ;
        end
      end

      FAULT: begin
        // A fetch abandoned on the way into FAULT still owes one response.
        if (kill && imem_rvalid) kill_nx = 1'b0;
        if (trap_valid && (trap_vector[1:0] == 2'b00)) begin
          pc_nx    = trap_vector;
          fault_nx = 1'b0;
          state_nx = REQ;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= RESET_VECTOR;
      kill           <= 1'b0;
      imem_req       <= 1'b0;
      imem_addr      <= RESET_VECTOR;
      inst_valid     <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      misalign_fault <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      kill           <= kill_nx;
      imem_req       <= (state_nx == REQ);
      imem_addr      <= pc_nx;
      inst_valid     <= valid_nx;
      inst           <= inst_nx;
      inst_pc        <= inst_pc_nx;
      misalign_fault <= fault_nx;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a small instruction-memory model answers requests,
// and expected grant addresses / delivered instructions are queued and checked in order.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_fault;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_inst[$];

  // Memory model: grants limited by gnt_budget, responds rsp_lat cycles after a grant.
  int          gnt_budget = 0;
  int          rsp_lat = 1;
  bit          force_dead = 1'b0;
  logic        gnt_q = 1'b0;
  logic [31:0] addr_q = '0;
  int          cnt = 0;
  logic [31:0] pend = '0;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (gnt_q) begin
      check("grant_expected", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) check("grant_addr", addr_q, exp_addr.pop_front());
      pend = force_dead ? 32'hDEAD_BEEF : mem_word(addr_q);
      cnt  = rsp_lat;
    end
    if (cnt != 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend;
      end
    end
    gnt_q = imem_req && (gnt_budget > 0);
    if (gnt_q) gnt_budget--;
    imem_gnt = gnt_q;
    addr_q   = imem_addr;
  end

  // Delivery monitor: each new inst_valid pulse must match the next queued instruction.
  logic valid_q = 1'b0;
  int   valid_cycles = 0;

  always @(negedge clk) begin
    if (inst_valid) valid_cycles++;
    if (inst_valid && !valid_q) begin
      check("inst_expected", 32'(exp_pc.size() != 0), 32'd1);
      if (exp_pc.size() != 0) begin
        check("inst_pc", inst_pc, exp_pc.pop_front());
        check("inst", inst, exp_inst.pop_front());
      end
    end
    valid_q = inst_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_pc.push_back(a);
    exp_inst.push_back(mem_word(a));
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_pc.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_addr.size() + exp_pc.size()), 32'd0);
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!inst_valid && n < limit) begin
      tick();
      n++;
    end
    check("valid_seen", 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_grants(input int limit);
    int n = 0;
    while (exp_addr.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("grants_seen", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic pulse_trap(input logic [31:0] v);
    trap_valid = 1'b1; trap_vector = v;
    tick();
    trap_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_pc"}, inst_pc, 32'h0);
    check({tag, "_fault"}, 32'(misalign_fault), 32'd0);
  endtask

  initial begin
    // Reset then three sequential fetches with immediate grant/response.
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    gnt_budget = 3;
    rst = 1'b1;
    drain(40);
    check("seq_valid_cycles", 32'(valid_cycles), 32'd3);
    check("seq_next_req", 32'(imem_req), 32'd1);
    check("seq_next_addr", imem_addr, 32'hC);

    // Decode stall holds the instruction and suppresses further requests.
    stall = 1'b1;
    expect_fetch(32'hC);
    gnt_budget = 1;
    wait_valid(20);
    for (int i = 0; i < 4; i++) begin
      check("stall_inst", inst, mem_word(32'hC));
      check("stall_pc", inst_pc, 32'hC);
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    check("unstall_valid", 32'(inst_valid), 32'd0);
    check("unstall_req", 32'(imem_req), 32'd1);
    check("unstall_addr", imem_addr, 32'h10);

    // Redirect while waiting: the late 0xDEADBEEF response must be dropped.
    rsp_lat = 3;
    force_dead = 1'b1;
    exp_addr.push_back(32'h10);
    gnt_budget = 1;
    wait_grants(20);
    force_dead = 1'b0;
    pulse_redirect(32'h200);
    check("kill_req_off", 32'(imem_req), 32'd0);
    rsp_lat = 1;
    expect_fetch(32'h200);
    gnt_budget = 1;
    drain(40);

    // Trap and redirect together in HOLD: trap wins, instruction squashed.
    stall = 1'b1;
    expect_fetch(32'h204);
    gnt_budget = 1;
    wait_valid(20);
    redirect_valid = 1'b1; redirect_target = 32'h300;
    pulse_trap(32'h100);
    redirect_valid = 1'b0;
    check("squash_valid", 32'(inst_valid), 32'd0);
    check("squash_req", 32'(imem_req), 32'd1);
    check("squash_addr", imem_addr, 32'h100);
    stall = 1'b0;
    expect_fetch(32'h100);
    gnt_budget = 1;
    drain(40);

    // Misaligned redirect faults; misaligned trap stays faulted; aligned trap recovers.
    pulse_redirect(32'h202);
    check("mis_fault", 32'(misalign_fault), 32'd1);
    check("mis_req", 32'(imem_req), 32'd0);
    repeat (2) tick();
    check("mis_req_hold", 32'(imem_req), 32'd0);
    pulse_trap(32'h101);
    check("mis_trap_fault", 32'(misalign_fault), 32'd1);
    check("mis_trap_req", 32'(imem_req), 32'd0);
    pulse_trap(32'h100);
    check("recover_fault", 32'(misalign_fault), 32'd0);
    check("recover_req", 32'(imem_req), 32'd1);
    check("recover_addr", imem_addr, 32'h100);
    expect_fetch(32'h100);
    gnt_budget = 1;
    drain(40);

    // PC wrap from 0xFFFF_FFFC to 0, then asynchronous reset in the middle of WAIT.
    pulse_redirect(32'hFFFF_FFFC);
    rsp_lat = 4;
    expect_fetch(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    gnt_budget = 2;
    wait_grants(40);
    check("wrap_inst_drained", 32'(exp_pc.size()), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (5) tick();
    rsp_lat = 1;
    expect_fetch(32'h0);
    gnt_budget = 1;
    rst = 1'b1;
    tick();
    check("post_rst_addr", imem_addr, 32'h0);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that owns the program counter of the single-cycle core and sequences instruction fetch over a request/grant/response handshake to instruction memory. It generates the PC value (sequential +4, branch/jump redirect, trap vector), issues one outstanding fetch at a time and presents the returned instruction to decode. It honours a downstream stall and discards responses made stale by a redirect. A misaligned target raises a fault.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset and the first fetch address
XLEN, 32, address/instruction width (only 32 supported)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
imem_req  output  1  fetch request, held until imem_gnt
imem_addr  output  32  fetch address, stable while imem_req=1
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid (1+ cycles after grant)
imem_rdata  input  32  instruction word
stall  input  1  decode cannot accept instruction this cycle
redirect_valid  input  1  branch/jump taken (1-cycle pulse)
redirect_target  input  32  redirect PC
trap_valid  input  1  trap request (1-cycle pulse)
trap_vector  input  32  trap handler address
inst_valid  output  1  inst/inst_pc valid for decode
inst  output  32  fetched instruction
inst_pc  output  32  PC of inst
misalign_fault  output  1  sticky: target bits[1:0] != 0

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst=0, inst_pc=0, misalign_fault=0, kill=0. Reset mid-transaction abandons it; later imem_rvalid ignored until a new grant.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> WAIT. Address never changes while req=1 and not granted, except trap/redirect (below).
- WAIT: imem_req=0. On imem_rvalid: if kill=1 drop data, clear kill, -> REQ (pc already at new target). Else inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 0), -> HOLD.
- HOLD: inst_valid=1. stall=0 consumes instruction: inst_valid<=0, -> REQ. stall=1: inst/inst_pc held stable.
- Redirect/trap target selection priority: trap_valid > redirect_valid > sequential. Simultaneous trap and redirect: trap wins, redirect lost.
- Event in REQ: pc<=target, imem_addr changes next cycle; if same-cycle imem_gnt=1, grant is for old addr -> WAIT with kill=1.
- Event in WAIT: pc<=target, kill<=1; if same-cycle imem_rvalid, data dropped, kill not set, -> REQ.
- Event in HOLD: inst_valid<=0 (squash, regardless of stall), pc<=target, -> REQ.
- Event in IDLE: pc<=target, -> REQ.
- Target with bits[1:0]!=0: misalign_fault<=1, inst_valid<=0, -> FAULT (any pending kill still drains one rvalid). FAULT: no requests; only trap_valid leaves (aligned vector -> REQ, fault cleared). Misaligned trap_vector re-enters FAULT.
- Latency: grant and response same-cycle-as-request-accept minimum: REQ(gnt) -> WAIT(rvalid) -> HOLD; back-to-back throughput one instruction per 3 cycles with stall=0.
- At most one outstanding fetch; imem_rvalid outside WAIT ignored.

Test Plan:
- Reset release, gnt/rvalid immediate, stall=0 -> imem_addr sequence 0x0,0x4,0x8; inst_pc matches; inst_valid 1 cycle per fetch.
- HOLD with stall=1 for 4 cycles -> inst/inst_pc unchanged, no imem_req until stall=0.
- redirect_valid target 0x200 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data dropped, next imem_addr=0x200, no inst_valid for killed word.
- Simultaneous trap_valid (0x100) and redirect_valid (0x300) in HOLD -> inst_valid squashed, next imem_addr=0x100.
- redirect_target 0x202 -> misalign_fault=1, imem_req=0; then trap_valid 0x100 -> fault clears, fetch at 0x100.
- pc=0xFFFF_FFFC fetched, then rst=0 asynchronously mid-WAIT -> all outputs reset immediately; after release first imem_addr=RESET_VECTOR; sequential wrap test gives next addr 0x0.
